// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES inverse-round datapath blocks.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } aes_fsm_t;

  typedef logic [127:0] aes_state_t;

  function automatic int unsigned beats_of(input int unsigned lanes);
    return 16 / lanes;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] INV = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign y = INV[a];

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// Multi-cycle InvSubBytes engine: LANES inverse S-box lookups per cycle,
// result presented on a valid/ready output.
module aes_inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned BEATS = beats_of(LANES);
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((16 % LANES) != 0) begin : g_bad_lanes
    $error("aes_inv_sub_bytes: LANES must divide 16");
  end

  aes_fsm_t   fsm;
  logic [BW-1:0] beat;
  aes_state_t st;
  aes_state_t nxt;
  logic [7:0] lut_in  [LANES];
  logic [7:0] lut_out [LANES];

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    aes_inv_sbox u_sbox (
      .a (lut_in[g]),
      .y (lut_out[g])
    );
  end

  // Byte select and in-place write-back use constant indices per beat so
  // the mux stays a plain decode of the beat counter.
  always_comb begin
    nxt = st;
    for (int unsigned l = 0; l < LANES; l++) lut_in[l] = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat == BW'(b)) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          lut_in[l] = st[127 - 8*(b*LANES + l) -: 8];
          nxt[127 - 8*(b*LANES + l) -: 8] = lut_out[l];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= ST_IDLE;
      beat      <= '0;
      st        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (in_valid) begin
            st       <= in_data;
            beat     <= '0;
            fsm      <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          st   <= nxt;
          beat <= beat + BW'(1);
          if (beat == BW'(BEATS - 1)) begin
            fsm       <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            fsm       <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          fsm       <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_data = st;

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Directed bench for aes_inv_sub_bytes at LANES = 4, 1 and 16 sharing one stimulus.
module tb_aes_inv_sub_bytes;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;

  logic         ir4, ov4, bz4;
  logic [127:0] od4;
  logic         ir1, ov1, bz1;
  logic [127:0] od1;
  logic         ir16, ov16, bz16;
  logic [127:0] od16;

  int checks = 0;
  int errors = 0;

  aes_inv_sub_bytes #(.LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .busy(bz4)
  );

  aes_inv_sub_bytes #(.LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(bz1)
  );

  aes_inv_sub_bytes #(.LANES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .in_data(in_data),
    .out_valid(ov16), .out_ready(out_ready), .out_data(od16), .busy(bz16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rt_in(input int k);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = SBOX[16*k + i];
    return r;
  endfunction

  function automatic logic [127:0] rt_exp(input int k);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = 8'(16*k + i);
    return r;
  endfunction

  task automatic send(input logic [127:0] d);
    @(negedge clk);
    chk("in_ready_before_send", {ir4, ir1, ir16}, 3'b111);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Requires out_ready high; measures latency of all three instances.
  task automatic collect(input string tag, input logic [127:0] exp);
    int lat4 = 0, lat1 = 0, lat16 = 0;
    logic [127:0] d4 = '0, d1 = '0, d16 = '0;
    for (int c = 1; c <= 40 && (lat4 == 0 || lat1 == 0 || lat16 == 0); c++) begin
      @(posedge clk);
      #1;
      if (ov4 && lat4 == 0) begin lat4 = c; d4 = od4; end
      if (ov1 && lat1 == 0) begin lat1 = c; d1 = od1; end
      if (ov16 && lat16 == 0) begin lat16 = c; d16 = od16; end
    end
    chk({tag, "_lat4"}, 128'(lat4), 128'd4);
    chk({tag, "_lat1"}, 128'(lat1), 128'd16);
    chk({tag, "_lat16"}, 128'(lat16), 128'd1);
    chk({tag, "_data4"}, d4, exp);
    chk({tag, "_data1"}, d1, exp);
    chk({tag, "_data16"}, d16, exp);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int seen;
    int last;
    int nacc;
    int nout;
    logic [127:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {ir4, ir1, ir16}, 3'b111);
    chk("rst_out_valid", {ov4, ov1, ov16}, 3'b000);
    chk("rst_busy", {bz4, bz1, bz16}, 3'b000);
    chk("rst_out_data", od4, '0);

    send(128'h637c777bf26b6fc53001672bfed7ab76);
    collect("fips", 128'h000102030405060708090a0b0c0d0e0f);

    send('0);
    collect("zeros", {16{8'h52}});

    // Output held off: all three park in DONE.
    out_ready = 1'b0;
    send({16{8'h16}});
    seen = 0;
    for (int c = 1; c <= 40 && seen == 0; c++) begin
      @(posedge clk);
      #1;
      if (ov4) seen = c;
    end
    chk("hold_lat4", 128'(seen), 128'd4);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("hold_out_valid", ov4, 1'b1);
      chk("hold_out_data", od4, {16{8'hff}});
      chk("hold_in_ready", ir4, 1'b0);
    end
    seen = 0;
    for (int c = 1; c <= 40 && seen == 0; c++) begin
      @(posedge clk);
      #1;
      if (ov1) seen = c;
    end
    chk("hold_lanes1_valid", 128'(seen != 0), 128'd1);
    chk("hold_lanes1_data", od1, {16{8'hff}});
    chk("hold_lanes16_data", od16, {16{8'hff}});
    chk("hold_lanes16_valid", ov16, 1'b1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_out_valid", ov4, 1'b0);
    chk("release_in_ready", ir4, 1'b1);
    repeat (2) @(posedge clk);

    for (int k = 0; k < 16; k++) begin
      send(rt_in(k));
      collect("roundtrip", rt_exp(k));
    end

    // Reset in the second RUN cycle of the LANES=4 instance.
    send(rt_in(3));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_in_ready", {ir4, ir1, ir16}, 3'b111);
    chk("midrun_out_valid", {ov4, ov1, ov16}, 3'b000);
    chk("midrun_busy", {bz4, bz1, bz16}, 3'b000);
    chk("midrun_out_data", od4, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (ov4 || ov1 || ov16) seen++;
    end
    chk("midrun_no_valid", 128'(seen), 128'd0);
    send(rt_in(9));
    collect("after_reset", rt_exp(9));

    // Back-to-back on the LANES=4 instance with in_valid held.
    out_ready = 1'b1;
    last = -1;
    nacc = 0;
    nout = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (ov4) begin
        held = rt_exp(4 + nout);
        chk("b2b_data", od4, held);
        nout++;
      end
      if (nacc < 4) begin
        in_valid = 1'b1;
        in_data  = rt_in(4 + nacc);
      end else begin
        in_valid = 1'b0;
      end
      if (ir4 && in_valid) begin
        if (last >= 0) chk("b2b_spacing", 128'(cyc - last), 128'd6);
        last = cyc;
        nacc++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 128'(nacc), 128'd4);
    chk("b2b_outputs", 128'(nout), 128'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_sub_bytes.md
# aes_inv_sub_bytes

Multi-cycle InvSubBytes engine for the AES decryption datapath. It accepts one 128-bit state and applies the AES inverse S-box to all 16 bytes, LANES bytes per cycle. It then presents the result on a valid/ready output. It is the decrypt-side counterpart of the forward S-box lookup used by SubBytes, and sits between InvShiftRows and AddRoundKey in the inverse round.

## Interface
- LANES, default 4: inverse S-box lookups per cycle. Legal values are 1, 2, 4, 8 and 16. BEATS = 16/LANES.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  input state valid.
- in_ready  output  1  engine can accept a state.
- in_data  input  128  ciphertext-side state. Byte 0 = in_data[127:120], byte 15 = in_data[7:0] (FIPS-197 order).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  128  InvSubBytes(in_data), with the same byte order.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM with three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: load in_data into the 128-bit state register, clear the beat counter, go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, replace bytes beat*LANES through beat*LANES+LANES-1 in place with their InvSbox values.
  - Increment the beat counter, which is ceil(log2(BEATS)) bits wide (minimum 1).
  - When beat == BEATS-1, go to DONE after this update.
- DONE:
  - out_valid = 1 and out_data = state register. Both are held stable until the handshake.
  - On out_ready, go to IDLE.
  - in_ready = 0, so there is no overlap between the output handshake and the next accept.
- out_data is driven from the state register at all times. It is only meaningful while out_valid is high.
- in_data is ignored outside an accepting cycle and may change freely after the accept.
- Once out_valid is high, it does not drop until out_ready is seen.
- in_valid while busy has no effect. The upstream must hold its data until in_ready.
- Inverse S-box: InvSbox(Sbox(x)) = x for all 256 x. Examples: InvSbox(00)=52, InvSbox(63)=00, InvSbox(16)=ff.

## Timing
- Reset values: state IDLE, beat 0, state register 0, out_valid 0, busy 0, in_ready 1.
- Reset is asynchronous. Deasserting rst_n mid-RUN or mid-DONE discards the block. No out_valid is produced for it.
- Latency: accept on edge T gives out_valid high from edge T+BEATS. This is 4 cycles for LANES=4 and 1 cycle for LANES=16.
- out_ready already high when DONE is entered: the handshake completes in the first DONE cycle, and in_ready is high on the next cycle.
- Minimum period between accepts is BEATS+2 cycles. That is BEATS in RUN, 1 in DONE and 1 in IDLE.
- out_ready held low: the engine stays in DONE indefinitely with out_data constant.
- Lookups are combinational in the same cycle. There is no registered ROM read.

## Structure
- Shared package aes_pkg holds:
  - the FSM state enum typedef;
  - the 128-bit aes_state_t typedef;
  - the function computing BEATS from LANES.
- One sub-module, aes_inv_sbox: a purely combinational 8-bit input to 8-bit output inverse S-box table with the same port shape as the forward S-box. Instantiate it LANES times.
- Byte selection is a LANES-wide mux indexed by beat; there are no other sub-modules.
- Add an elaboration-time assertion that LANES divides 16.

## Test plan
- Reset, then one beat with rst_n high: in_ready=1, out_valid=0, busy=0, out_data=0.
- LANES=4, in_data=637c777bf26b6fc53001672bfed7ab76 -> out_data=000102030405060708090a0b0c0d0e0f. out_valid rises exactly 4 cycles after the accept.
- All-zero input -> all bytes 52. All bytes 16 -> all bytes ff. Hold out_ready low for 10 cycles: out_valid and out_data stay stable, and in_ready stays 0 throughout.
- Exhaustive round-trip: feed 16 states covering every Sbox(x) for x = 00..ff -> every output byte equals x. Repeat for LANES=1 and LANES=16, checking latencies of 16 and 1.
- Pull rst_n low in the 2nd RUN cycle -> outputs return to their reset values immediately. No out_valid occurs for that block, and the next block processes correctly.
- Back-to-back blocks with out_ready tied high and in_valid held -> accepts are spaced exactly BEATS+2 cycles apart, and no block is lost or duplicated.
